// File: rtl/icache_if.sv
// CPU fetch port and instruction-memory block port of the instruction cache.
// The cache is the slave; the CPU/memory environment is the master.
interface icache_if;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    modport slave (
        input  PC, MEM_READDATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

    modport master (
        output PC, MEM_READDATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 8 lines of 16-byte blocks, combinational
// hit path, and a three-state fill sequencer that stalls the CPU through BUSYWAIT.
module icache #(
    parameter int NUM_BLOCKS = 8,
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 3
) (
    input  logic     CLK,
    input  logic     RESET,
    icache_if.slave  bus
);
    localparam int OFFS_LSB = 4;
    localparam int ADDR_W   = TAG_BITS + INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

    state_t                state, next_state;
    logic [NUM_BLOCKS-1:0] valid;
    logic [TAG_BITS-1:0]   tags   [NUM_BLOCKS];
    logic [127:0]          data_q [NUM_BLOCKS];
    logic [ADDR_W-1:0]     fill_addr;
    logic [31:0]           instr_q;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [1:0]            off;
    logic                  pc_none;
    logic                  hit;
    logic                  hit_ok;
    logic                  fill_done;
    logic                  busy;
    logic                  mem_read;
    logic [ADDR_W-1:0]     mem_addr;
    logic [31:0]           word;

    assign idx     = bus.PC[OFFS_LSB +: INDEX_BITS];
    assign tag     = bus.PC[OFFS_LSB + INDEX_BITS +: TAG_BITS];
    assign off     = bus.PC[3:2];
    // The CPU's own reset PC is not a real fetch and must never start a fill.
    assign pc_none = (bus.PC == 32'hFFFF_FFFC);
    assign hit     = valid[idx] && (tags[idx] == tag);
    assign hit_ok  = (state == S_IDLE) && !pc_none && hit;
    assign fill_done = (state == S_MEM_READ) && !bus.MEM_BUSYWAIT;

    always_comb begin
        word = data_q[idx][31:0];
        case (off)
            2'd0: word = data_q[idx][31:0];
            2'd1: word = data_q[idx][63:32];
            2'd2: word = data_q[idx][95:64];
            2'd3: word = data_q[idx][127:96];
            default: word = data_q[idx][31:0];
        endcase
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        mem_read   = 1'b0;
        mem_addr   = '0;
        case (state)
            S_IDLE: begin
                if (!pc_none && !hit) begin
                    busy       = 1'b1;
                    next_state = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = fill_addr;
                if (!bus.MEM_BUSYWAIT)
                    next_state = S_UPDATE;
            end
            S_UPDATE: begin
                busy       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // While RESET is held the CPU is never stalled, even if the current PC would miss.
    assign bus.BUSYWAIT    = busy && !RESET;
    assign bus.MEM_READ    = mem_read;
    assign bus.MEM_ADDRESS = mem_addr;
    assign bus.INSTRUCTION = (hit_ok && !RESET) ? word : instr_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            valid   <= '0;
            instr_q <= '0;
        end else begin
            state <= next_state;
            if (fill_done)
                valid[fill_addr[INDEX_BITS-1:0]] <= 1'b1;
            if (hit_ok)
                instr_q <= word;
        end
    end

    // Line payload and the latched fill address; valid alone decides whether they are used.
    always_ff @(posedge CLK) begin
        if (state == S_IDLE && next_state == S_MEM_READ)
            fill_addr <= {tag, idx};
        if (fill_done) begin
            data_q[fill_addr[INDEX_BITS-1:0]] <= bus.MEM_READDATA;
            tags[fill_addr[INDEX_BITS-1:0]]   <= fill_addr[ADDR_W-1:INDEX_BITS];
        end
    end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: block memory model, vector table replayed through a scoreboard,
// plus reset-related and no-access sequences.
module tb_icache;
    logic CLK = 1'b0;
    logic RESET;

    icache_if bus ();

    icache dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Memory: block k word w = {k, w, 24'h0}; ready on the 5th MEM_READ cycle.
    logic [3:0] mcnt;
    always @(posedge CLK) begin
        if (RESET || !bus.MEM_READ) mcnt <= 4'd0;
        else                        mcnt <= mcnt + 4'd1;
    end
    assign bus.MEM_BUSYWAIT = bus.MEM_READ && (mcnt != 4'd4);

    function automatic logic [127:0] mk_block(input logic [5:0] k);
        logic [127:0] b;
        for (int w = 0; w < 4; w++)
            b[w*32 +: 32] = {k, w[1:0], 24'h0};
        return b;
    endfunction
    assign bus.MEM_READDATA = mk_block(bus.MEM_ADDRESS);

    typedef struct {
        logic [31:0] pc;
        logic        miss;
        logic [5:0]  addr;
        logic [31:0] instr;
    } vec_t;

    typedef struct {
        int          busy;
        logic        miss;
        logic [5:0]  addr;
        logic [31:0] instr;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[15];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_access(input logic [31:0] pc, input logic miss,
                             input logic [5:0] addr, input logic [31:0] instr);
        exp_t e;
        exp_t g;
        int   busy;
        logic seen_read;
        logic [5:0] seen_addr;
        e.busy  = miss ? 7 : 0;
        e.miss  = miss;
        e.addr  = addr;
        e.instr = instr;
        sb_q.push_back(e);
        @(negedge CLK);
        bus.PC = pc;
        #1;
        busy = 0;
        seen_read = 1'b0;
        seen_addr = '0;
        while (bus.BUSYWAIT === 1'b1 && busy < 40) begin
            busy++;
            if (bus.MEM_READ === 1'b1) begin
                seen_read = 1'b1;
                seen_addr = bus.MEM_ADDRESS;
            end
            @(negedge CLK);
            #1;
        end
        g = sb_q.pop_front();
        chk($sformatf("busy_cycles pc=%h", pc), busy, g.busy);
        chk($sformatf("mem_read_seen pc=%h", pc), {31'd0, seen_read}, {31'd0, g.miss});
        if (g.miss)
            chk($sformatf("mem_address pc=%h", pc), {26'd0, seen_addr}, {26'd0, g.addr});
        chk($sformatf("instruction pc=%h", pc), bus.INSTRUCTION, g.instr);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.BUSYWAIT === 1'b1 && n < 40) begin
            n++;
            @(negedge CLK);
            #1;
        end
        chk(name, {31'd0, bus.BUSYWAIT}, 32'd0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{32'h0000_0000, 1'b1, 6'h00, 32'h0000_0000};
        vecs[1]  = '{32'h0000_0004, 1'b0, 6'h00, 32'h0100_0000};
        vecs[2]  = '{32'h0000_0008, 1'b0, 6'h00, 32'h0200_0000};
        vecs[3]  = '{32'h0000_000C, 1'b0, 6'h00, 32'h0300_0000};
        vecs[4]  = '{32'h0000_0080, 1'b1, 6'h08, 32'h2000_0000};
        vecs[5]  = '{32'h0000_0000, 1'b1, 6'h00, 32'h0000_0000};
        vecs[6]  = '{32'h0000_0010, 1'b1, 6'h01, 32'h0400_0000};
        vecs[7]  = '{32'h0000_0020, 1'b1, 6'h02, 32'h0800_0000};
        vecs[8]  = '{32'h0000_003C, 1'b1, 6'h03, 32'h0F00_0000};
        vecs[9]  = '{32'h0000_0000, 1'b0, 6'h00, 32'h0000_0000};
        vecs[10] = '{32'h0000_0014, 1'b0, 6'h00, 32'h0500_0000};
        vecs[11] = '{32'h0000_0028, 1'b0, 6'h00, 32'h0A00_0000};
        vecs[12] = '{32'h0000_0303, 1'b1, 6'h30, 32'hC000_0000};
        vecs[13] = '{32'hFFFF_F004, 1'b1, 6'h00, 32'h0100_0000};
        vecs[14] = '{32'h0000_0008, 1'b0, 6'h00, 32'h0200_0000};

        RESET  = 1'b1;
        bus.PC = 32'hFFFF_FFFC;
        repeat (2) @(negedge CLK);
        #1;
        chk("reset_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
        chk("reset_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
        chk("reset_mem_address", {26'd0, bus.MEM_ADDRESS}, 32'd0);
        chk("reset_instruction", bus.INSTRUCTION, 32'd0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("pc_none_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
        chk("pc_none_mem_read", {31'd0, bus.MEM_READ}, 32'd0);

        for (int i = 0; i < 15; i++)
            do_access(vecs[i].pc, vecs[i].miss, vecs[i].addr, vecs[i].instr);

        // No-access PC keeps the last instruction and never requests memory.
        @(negedge CLK);
        bus.PC = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
            chk("hold_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
            chk("hold_instruction", bus.INSTRUCTION, 32'h0200_0000);
            @(negedge CLK);
        end

        // Reset on the 3rd memory-busy cycle of a fill.
        bus.PC = 32'h0000_0040;
        #1;
        chk("abort_miss_detect", {31'd0, bus.BUSYWAIT}, 32'd1);
        n = 0;
        while (n < 3) begin
            @(negedge CLK);
            #1;
            if (bus.MEM_READ === 1'b1 && bus.MEM_BUSYWAIT === 1'b1) n++;
            else if (bus.MEM_READ !== 1'b1) begin
                n = 99;
                chk("abort_fill_running", {31'd0, bus.MEM_READ}, 32'd1);
            end
        end
        RESET = 1'b1;
        @(negedge CLK);
        #1;
        chk("abort_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
        chk("abort_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
        RESET = 1'b0;
        #1;
        chk("abort_remiss", {31'd0, bus.BUSYWAIT}, 32'd1);
        wait_idle("abort_refill_done");
        chk("abort_refill_instr", bus.INSTRUCTION, 32'h1000_0000);

        // All lines were invalidated by that reset.
        do_access(32'h0000_0008, 1'b1, 6'h00, 32'h0200_0000);

        // Reset coinciding with fill completion: line must stay invalid.
        @(negedge CLK);
        bus.PC = 32'h0000_0050;
        n = 0;
        #1;
        while (!(bus.MEM_READ === 1'b1 && bus.MEM_BUSYWAIT === 1'b0) && n < 40) begin
            n++;
            @(negedge CLK);
            #1;
        end
        chk("race_fill_reached", {31'd0, bus.MEM_READ}, 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        #1;
        chk("race_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
        chk("race_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
        RESET = 1'b0;
        #1;
        chk("race_line_invalid", {31'd0, bus.BUSYWAIT}, 32'd1);
        wait_idle("race_refill_done");
        chk("race_refill_instr", bus.INSTRUCTION, 32'h1400_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
